// File: rtl/ltpi_frame_aligner_pkg.sv
// Shared LTPI definitions: comma symbol, aligner state encoding and default frame length.
package ltpi_frame_aligner_pkg;

    localparam logic [7:0] LTPI_COMMA             = 8'hBC;
    localparam int         LTPI_FRAME_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        VERIFY  = 2'd1,
        ALIGNED = 2'd2
    } aligner_state_t;

endpackage

// File: rtl/ltpi_frame_aligner_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module ltpi_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ltpi_frame_aligner.sv
// LTPI frame aligner: hunts K28.5 commas, verifies frame spacing, forwards aligned frames.
// Optional symbol-error counter enabled by defining LTPI_FRAME_ALIGNER_ERR_CNT_EN.
module ltpi_frame_aligner
    import ltpi_frame_aligner_pkg::*;
#(
    parameter int FRAME_LEN  = LTPI_FRAME_LEN_DEFAULT,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [7:0]  sym_data,
    input  logic        sym_is_k,
    input  logic        sym_err,
    output logic        aligned,
    output logic        frm_valid,
    output logic [7:0]  frm_data,
    output logic        frm_is_k,
    output logic        frm_sof,
    output logic        frm_eof,
    output logic        frm_abort,
`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
    output logic [15:0] sym_err_cnt,
`endif
    output logic [15:0] lost_align_cnt
);

    localparam int               POS_W      = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(FRAME_LEN - 1);
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_TGT = 4'(UNLOCK_CNT);

    aligner_state_t   state_reg, state_next;
    logic [POS_W-1:0] pos_reg, pos_next, pos_adv;
    logic [3:0]       good_reg, good_next;
    logic [3:0]       bad_reg, bad_next;
    logic             fwd_next, sof_next, eof_next, abort_next;
    logic             is_comma, at_slot;

    assign is_comma = sym_is_k && (sym_data == LTPI_COMMA);
    assign at_slot  = (pos_reg == '0);
    assign pos_adv  = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        good_next  = good_reg;
        bad_next   = bad_reg;
        fwd_next   = 1'b0;
        sof_next   = 1'b0;
        eof_next   = 1'b0;
        abort_next = 1'b0;
        if (sym_valid) begin
            pos_next = pos_adv;
            unique case (state_reg)
                HUNT: begin
                    if (is_comma) begin
                        // The comma itself occupies slot 0, so the next symbol is slot 1.
                        pos_next  = POS_W'(1);
                        good_next = 4'd1;
                        bad_next  = 4'd0;
                        if (LOCK_CNT == 1) begin
                            state_next = ALIGNED;
                            fwd_next   = 1'b1;
                            sof_next   = 1'b1;
                        end else begin
                            state_next = VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (at_slot) begin
                        if (is_comma) begin
                            good_next = good_reg + 4'd1;
                            if ((good_reg + 4'd1) == LOCK_TGT) begin
                                state_next = ALIGNED;
                                bad_next   = 4'd0;
                                fwd_next   = 1'b1;
                                sof_next   = 1'b1;
                            end
                        end else begin
                            state_next = HUNT;
                            good_next  = 4'd0;
                        end
                    end else if (is_comma) begin
                        pos_next  = POS_W'(1);
                        good_next = 4'd1;
                    end
                end
                ALIGNED: begin
                    fwd_next = 1'b1;
                    sof_next = at_slot;
                    eof_next = (pos_reg == POS_LAST);
                    if (at_slot) begin
                        if (is_comma) begin
                            bad_next = 4'd0;
                        end else if ((bad_reg + 4'd1) == UNLOCK_TGT) begin
                            // Lock lost: swallow this symbol and flag the partial frame.
                            state_next = HUNT;
                            bad_next   = 4'd0;
                            good_next  = 4'd0;
                            fwd_next   = 1'b0;
                            sof_next   = 1'b0;
                            abort_next = 1'b1;
                        end else begin
                            bad_next = bad_reg + 4'd1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= HUNT;
            pos_reg   <= '0;
            good_reg  <= '0;
            bad_reg   <= '0;
            aligned   <= 1'b0;
            frm_valid <= 1'b0;
            frm_data  <= '0;
            frm_is_k  <= 1'b0;
            frm_sof   <= 1'b0;
            frm_eof   <= 1'b0;
            frm_abort <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            good_reg  <= good_next;
            bad_reg   <= bad_next;
            aligned   <= (state_next == ALIGNED);
            frm_valid <= fwd_next;
            frm_data  <= fwd_next ? sym_data : 8'h00;
            frm_is_k  <= fwd_next & sym_is_k;
            frm_sof   <= sof_next;
            frm_eof   <= eof_next;
            frm_abort <= abort_next;
        end
    end

    ltpi_sat_counter #(.WIDTH(16)) u_lost_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (abort_next),
        .count (lost_align_cnt)
    );

`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
    ltpi_sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sym_valid & sym_err),
        .count (sym_err_cnt)
    );
`else
    logic unused_sym_err;
    assign unused_sym_err = sym_err;
`endif

endmodule

// File: tb/tb_ltpi_frame_aligner.sv
// Scoreboard bench for ltpi_frame_aligner (FRAME_LEN=16, LOCK_CNT=3, UNLOCK_CNT=4).
module tb_ltpi_frame_aligner;

    localparam int FL = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sym_valid = 1'b0;
    logic [7:0]  sym_data = 8'h00;
    logic        sym_is_k = 1'b0;
    logic        sym_err = 1'b0;
    logic        aligned, frm_valid, frm_is_k, frm_sof, frm_eof, frm_abort;
    logic [7:0]  frm_data;
    logic [15:0] lost_align_cnt;
`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
    logic [15:0] sym_err_cnt;
`endif

    always #5 clk = ~clk;

    ltpi_frame_aligner #(.FRAME_LEN(FL), .LOCK_CNT(3), .UNLOCK_CNT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_is_k       (sym_is_k),
        .sym_err        (sym_err),
        .aligned        (aligned),
        .frm_valid      (frm_valid),
        .frm_data       (frm_data),
        .frm_is_k       (frm_is_k),
        .frm_sof        (frm_sof),
        .frm_eof        (frm_eof),
        .frm_abort      (frm_abort),
`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
        .sym_err_cnt    (sym_err_cnt),
`endif
        .lost_align_cnt (lost_align_cnt)
    );

    typedef struct {
        int          due;
        logic        abort;
        logic [7:0]  data;
        logic        is_k;
        logic        sof;
        logic        eof;
        logic        al;
        logic [15:0] lost;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented output must match the entry due in this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_output cyc=%0d: no output, required data=%02h abort=%0b",
                         cyc, exp_q[0].data, exp_q[0].abort);
                void'(exp_q.pop_front());
            end
            if (frm_valid || frm_abort) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d: valid=%0b abort=%0b data=%02h, required none",
                             cyc, frm_valid, frm_abort, frm_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({frm_abort, frm_valid, frm_data, frm_is_k, frm_sof, frm_eof, aligned, lost_align_cnt} !==
                        {e.abort, !e.abort, e.data, e.is_k, e.sof, e.eof, e.al, e.lost}) begin
                        errors++;
                        $display("FAIL frame_output cyc=%0d: got v=%0b d=%02h k=%0b sof=%0b eof=%0b abort=%0b al=%0b lost=%0d, required v=%0b d=%02h k=%0b sof=%0b eof=%0b abort=%0b al=%0b lost=%0d",
                                 cyc, frm_valid, frm_data, frm_is_k, frm_sof, frm_eof, frm_abort, aligned, lost_align_cnt,
                                 !e.abort, e.data, e.is_k, e.sof, e.eof, e.abort, e.al, e.lost);
                    end else begin
                        $display("ok  cyc=%0d d=%02h k=%0b sof=%0b eof=%0b abort=%0b al=%0b lost=%0d",
                                 cyc, frm_data, frm_is_k, frm_sof, frm_eof, frm_abort, aligned, lost_align_cnt);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok  %s = %0h", name, act);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic err,
                         input logic fwd, input logic abrt, input logic sof, input logic eof,
                         input logic al, input logic [15:0] lost);
        exp_t e;
        @(posedge clk);
        #1;
        sym_valid = v;
        sym_data  = d;
        sym_is_k  = k;
        sym_err   = err;
        if (fwd || abrt) begin
            e.due   = cyc + 1;
            e.abort = abrt;
            e.data  = fwd ? d : 8'h00;
            e.is_k  = fwd & k;
            e.sof   = sof;
            e.eof   = eof;
            e.al    = al;
            e.lost  = lost;
            exp_q.push_back(e);
        end
    endtask

    // One frame: slot 0 is a comma or a non-comma K28.0; slots 1..15 are data.
    task automatic frame(input logic comma, input logic fwd, input logic al, input logic abort_first,
                         input logic gaps, input logic [7:0] seed, input logic [15:0] lost);
        logic [7:0] d;
        logic       k;
        logic       fw;
        fw = fwd && !abort_first;
        for (int i = 0; i < FL; i++) begin
            if (i == 0) begin
                d = comma ? 8'hBC : 8'h1C;
                k = 1'b1;
            end else begin
                d = seed + 8'(i);
                k = 1'b0;
            end
            if (i == 0 && abort_first)
                drive(1'b1, d, k, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lost);
            else
                drive(1'b1, d, k, 1'b0, fw, 1'b0, fw && (i == 0), fw && (i == FL - 1), al, lost);
            if (gaps)
                drive(1'b0, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        sym_valid = 1'b0;
        sym_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Commas presented while reset is held must produce nothing.
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        check("reset_aligned", 32'(aligned), 32'd0);
        check("reset_frm_valid", 32'(frm_valid), 32'd0);
        check("reset_frm_sof", 32'(frm_sof), 32'd0);
        check("reset_frm_abort", 32'(frm_abort), 32'd0);
        check("reset_lost_cnt", 32'(lost_align_cnt), 32'd0);
`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
        check("reset_err_cnt", 32'(sym_err_cnt), 32'd0);
`endif
        reset     = 1'b0;
        sym_valid = 1'b0;

        // Clean stream: third comma locks and its frame is the first forwarded.
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 16'd0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 16'd0);
        @(negedge clk);
        check("aligned_after_two_commas", 32'(aligned), 32'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 16'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 16'd0);

        // Three missing commas then a good frame: lock holds.
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h60, 16'd0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h70, 16'd0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 16'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h90, 16'd0);

        // Four missing commas: fourth slot aborts and drops lock.
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 16'd0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB0, 16'd0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC0, 16'd0);
        frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hD0, 16'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        check("aligned_after_loss", 32'(aligned), 32'd0);
        check("lost_cnt_after_loss", 32'(lost_align_cnt), 32'd1);

        // Valid/idle alternation with ignored idle commas: lock after the same symbol count.
        do_reset();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 16'd0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 16'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 16'd0);
        @(negedge clk);
        check("aligned_held_in_gap", 32'(aligned), 32'd1);

        // Spurious comma at slot 7 with good=2 re-anchors the frame.
        do_reset();
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 16'd0);
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i < 7; i++)
            drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = 1; i < FL; i++)
            drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h70, 16'd0);
        @(negedge clk);
        check("aligned_before_reanchor_lock", 32'(aligned), 32'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 16'd0);

`ifdef LTPI_FRAME_ALIGNER_ERR_CNT_EN
        // Symbol errors in HUNT are counted but do not disturb the state machine.
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'(8'h05 + i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        check("sym_err_cnt", 32'(sym_err_cnt), 32'd5);
        check("aligned_with_errors", 32'(aligned), 32'd0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 16'd0);
        frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 16'd0);
        frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h30, 16'd0);
`endif

        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
